uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one `uart_byte_tx` instance between NUM_REQ byte producers using round-robin arbitration. The block sequences the transmitter:
- latches the granted byte;
- holds `send_en` for the whole frame;
- releases it on `tx_done`;
- waits for `tx_done` to clear before the next grant.

A watchdog aborts a frame that never completes. It sits between the application byte sources and `uart_byte_tx`.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT_CYC, 70000, Clk cycles allowed in SEND before abort (covers 12 bit-times at 9600 bps, 50 MHz)

Ports:
Clk  input  1  system clock; one clock domain
Reset_n  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester request, level, held until ack
req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i]
ack  output  NUM_REQ  one-hot, one-cycle pulse: byte of that requester accepted
owner  output  $clog2(NUM_REQ)  index of the current or last granted requester
busy  output  1  high from grant until return to IDLE
done  output  1  one-cycle pulse: frame completed (tx_done seen)
err  output  1  one-cycle pulse: frame aborted by timeout
tx_send_en  output  1  to uart_byte_tx send_en
tx_data  output  8  to uart_byte_tx Data; stable while tx_send_en=1
tx_done  input  1  from uart_byte_tx tx_done; level, not a pulse

Behaviour:
- Reset values: tx_send_en=0, tx_data=0, ack=0, owner=0, busy=0, done=0, err=0, state=IDLE, timeout counter=0, rr_last=NUM_REQ-1 (requester 0 wins first).
- Reset is asynchronous. Asserting it mid-frame drops tx_send_en immediately; the aborted frame is neither reported as done nor as err.
- All outputs are registered.
- State IDLE:
  - Grant is allowed only when |req=1 and tx_done=0. A stale-high tx_done blocks granting.
  - Winner = first requester with req=1 searching rr_last+1, rr_last+2, ... modulo NUM_REQ.
  - At the clock edge: tx_data<=winner's byte, ack[winner]<=1 for one cycle, owner<=winner, rr_last<=winner, tx_send_en<=1, busy<=1, counter<=0, go to SEND.
  - Latency from req high in IDLE to ack/tx_send_en high is 1 cycle.
- State SEND:
  - tx_send_en held at 1; tx_data unchanged.
  - If tx_done=1: tx_send_en<=0, done<=1 for one cycle, go to WAIT_LOW.
  - Else if counter==TIMEOUT_CYC-1: tx_send_en<=0, err<=1 for one cycle, go to WAIT_LOW.
  - Else counter+1.
  - tx_done has priority over timeout in the same cycle.
- State WAIT_LOW:
  - tx_send_en=0.
  - When tx_done=0: busy<=0, go to IDLE.
  - This guarantees at least one cycle of send_en low between frames, which resets the transmitter counters.
- Requester rules:
  - Data is sampled only in the grant cycle; the requester may change req_data after ack.
  - Dropping req before ack withdraws the request; no ack is given.
  - req still high after ack means a new byte is requested; it is eligible again, behind the other requesters in round-robin order.
- Counter width is $clog2(TIMEOUT_CYC); it never wraps past TIMEOUT_CYC-1.
- baud_set is outside this block; the arbiter is baud-agnostic.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams ST_IDLE=0, ST_SEND=1, ST_WAIT_LOW=2;
  - baud divisor constants (5208, 2604, 1302, 868, 434);
  - default TIMEOUT_CYC.
- One sub-module, `rr_arbiter`: a combinational round-robin grant from req and rr_last, producing a one-hot grant, an index, and a valid flag.
- The FSM, counter and output registers stay in uart_tx_arbiter.

Test Plan:
- Single byte:
  - Stimulus: req=01, req_data[7:0]=8'hA5; bench transmitter model raises tx_done 100 cycles after send_en.
  - Response: ack=01 one cycle after req; tx_data=A5 and tx_send_en=1 for 100 cycles; done pulse; busy low after tx_done clears.
- Simultaneous:
  - Stimulus: req=11 held continuously, data 8'h11 and 8'h22.
  - Response: grant order 0,1,0,1; tx_data sequence 11,22,11,22; exactly one ack per frame.
- Stale done:
  - Stimulus: tx_done forced 1 in IDLE with req=01.
  - Response: no ack and tx_send_en=0 until tx_done=0; then grant next cycle.
- Timeout:
  - Stimulus: TIMEOUT_CYC=50, tx_done held 0.
  - Response: tx_send_en high exactly 50 cycles; err pulse once; done never; returns to IDLE and can grant again.
- Reset mid-frame:
  - Stimulus: Reset_n low for 3 cycles during SEND.
  - Response: tx_send_en, busy, ack, done and err all 0 immediately; after release, requester 0 wins first.
- Withdrawal:
  - Stimulus: req[1] pulsed high for one cycle while busy with requester 0.
  - Response: no ack[1]; after frame 0 completes the block stays IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: arbiter state encoding, baud divisors at 50 MHz and the default frame watchdog.
package uart_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SEND     = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE     = ST_IDLE,
    S_SEND     = ST_SEND,
    S_WAIT_LOW = ST_WAIT_LOW
  } tx_state_e;

  localparam int BAUD_DIV_9600   = 32'd5208;
  localparam int BAUD_DIV_19200  = 32'd2604;
  localparam int BAUD_DIV_38400  = 32'd1302;
  localparam int BAUD_DIV_57600  = 32'd868;
  localparam int BAUD_DIV_115200 = 32'd434;

  // 12 bit-times at 9600 bps on a 50 MHz clock, with margin
  localparam int DEFAULT_TIMEOUT_CYC = 32'd70000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the first requester after rr_last (modulo N) wins.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  // Scan from farthest to nearest so the nearest requester after rr_last overwrites the others
  always_comb begin
    logic [IW-1:0] cand_s;
    logic          hit_s;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = N; k >= 1; k--) begin
      cand_s      = IW'((int'(rr_last) + k) % N);
      hit_s       = req[cand_s];
      grant_idx   = hit_s ? cand_s : grant_idx;
      grant_valid = grant_valid | hit_s;
    end
  end

  // One-hot form of the selected index
  always_comb begin
    grant            = '0;
    grant[grant_idx] = grant_valid;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_byte_tx between NUM_REQ byte producers, with a frame watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       tx_send_en,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC);

  tx_state_e            state_r;
  logic [CW-1:0]        cnt_r;
  logic [IW-1:0]        rr_last_r;
  logic [NUM_REQ-1:0]   grant_s;
  logic [IW-1:0]        grant_idx_s;
  logic                 grant_valid_s;
  logic [7:0]           byte_s;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req         (req),
    .rr_last     (rr_last_r),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Byte of the winning requester, selected by the one-hot grant
  always_comb begin
    byte_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      byte_s = byte_s | (req_data[8*i +: 8] & {8{grant_s[i]}});
    end
  end

  // Frame sequencer: grant, hold send_en until tx_done or watchdog, then wait for tx_done low
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r    <= S_IDLE;
      cnt_r      <= '0;
      rr_last_r  <= IW'(NUM_REQ - 1);
      ack        <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      tx_send_en <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      ack  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // A stale-high tx_done means the transmitter has not yet seen send_en drop
          if (grant_valid_s && !tx_done) begin
            tx_data    <= byte_s;
            ack        <= grant_s;
            owner      <= grant_idx_s;
            rr_last_r  <= grant_idx_s;
            tx_send_en <= 1'b1;
            busy       <= 1'b1;
            cnt_r      <= '0;
            state_r    <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_done) begin
            tx_send_en <= 1'b0;
            done       <= 1'b1;
            state_r    <= S_WAIT_LOW;
          end else if (cnt_r == CW'(TIMEOUT_CYC - 1)) begin
            tx_send_en <= 1'b0;
            err        <= 1'b1;
            state_r    <= S_WAIT_LOW;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_WAIT_LOW: begin
          tx_send_en <= 1'b0;
          if (!tx_done) begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          tx_send_en <= 1'b0;
          busy       <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a behavioural transmitter and round-robin model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 130;

  logic           Clk = 1'b0;
  logic           Reset_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic [1:0]     owner;
  logic           busy, done, err, tx_send_en, tx_done;
  logic [7:0]     tx_data;

  logic model_done = 1'b0;
  int   m_cnt      = 0;
  logic force_done;
  bit   model_en;
  int   frame_len;

  int errors = 0;
  int checks = 0;
  int exp_last;

  assign tx_done = model_done | force_done;

  always #5 Clk = ~Clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .owner      (owner),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .tx_send_en (tx_send_en),
    .tx_data    (tx_data),
    .tx_done    (tx_done)
  );

  // Transmitter model: tx_done rises frame_len cycles after send_en, falls once send_en drops
  always @(negedge Clk) begin
    if (tx_send_en && model_en) begin
      if (m_cnt == frame_len - 1) model_done <= 1'b1;
      else                        m_cnt      <= m_cnt + 1;
    end else begin
      model_done <= 1'b0;
      m_cnt      <= 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic reset_dut();
    Reset_n = 1'b0;
    repeat (3) tick();
    Reset_n  = 1'b1;
    exp_last = N - 1;
  endtask

  task automatic check_grant(input string tag, input int w, input logic [7:0] d);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (ack != '0) seen = 1'b1;
    end
    chk({tag, "_seen"},  32'(seen), 32'd1);
    chk({tag, "_ack"},   32'(ack), 32'd1 << w);
    chk({tag, "_owner"}, 32'(owner), 32'(w));
    chk({tag, "_data"},  32'(tx_data), 32'(d));
    chk({tag, "_sen"},   32'(tx_send_en), 32'd1);
    exp_last = w;
  endtask

  task automatic observe(input logic [7:0] d, output int hi, output int nd, output int ne,
                         output int na, output int bad, output bit ended);
    hi = 1; nd = 0; ne = 0; na = 0; bad = 0; ended = 1'b0;
    for (int i = 0; i < 400 && !ended; i++) begin
      tick();
      if (tx_send_en) begin
        hi++;
        if (tx_data !== d) bad++;
      end
      if (done) nd++;
      if (err) ne++;
      if (ack != '0) na++;
      if (!busy) ended = 1'b1;
    end
  endtask

  initial begin
    int hi, nd, ne, na, bad, w, idle_bad;
    bit ended;
    logic [31:0] r;

    Reset_n    = 1'b0;
    req        = '0;
    req_data   = '0;
    force_done = 1'b0;
    model_en   = 1'b1;
    frame_len  = 100;
    exp_last   = N - 1;

    // reset state
    repeat (3) tick();
    chk("rst_sen",   32'(tx_send_en), 32'd0);
    chk("rst_data",  32'(tx_data), 32'd0);
    chk("rst_ack",   32'(ack), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    Reset_n = 1'b1;
    tick();

    // single byte, 100-cycle frame
    req = 4'b0001; req_data[7:0] = 8'hA5;
    check_grant("t1", 0, 8'hA5);
    chk("t1_busy", 32'(busy), 32'd1);
    req = '0; req_data = $urandom;
    observe(8'hA5, hi, nd, ne, na, bad, ended);
    chk("t1_hi", 32'(hi), 32'd100);
    chk("t1_done", 32'(nd), 32'd1);
    chk("t1_err", 32'(ne), 32'd0);
    chk("t1_stable", 32'(bad), 32'd0);
    chk("t1_idle", 32'(ended), 32'd1);

    // simultaneous requests held continuously
    reset_dut();
    frame_len = 10;
    req = 4'b0011; req_data = 32'h0000_2211;
    for (int f = 0; f < 4; f++) begin
      w = rr_pick(req, exp_last);
      check_grant("t2", w, req_data[8*w +: 8]);
      if (f == 3) req = '0;
      observe(req_data[8*w +: 8], hi, nd, ne, na, bad, ended);
      chk("t2_one_ack", 32'(na), 32'd0);
      chk("t2_done", 32'(nd), 32'd1);
    end

    // stale tx_done blocks granting
    force_done = 1'b1;
    req = 4'b0001; req_data[7:0] = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_noack", 32'(ack), 32'd0);
      chk("t3_nosen", 32'(tx_send_en), 32'd0);
    end
    force_done = 1'b0;
    tick();
    chk("t3_ack", 32'(ack), 32'd1);
    chk("t3_sen", 32'(tx_send_en), 32'd1);
    chk("t3_data", 32'(tx_data), 32'h3C);
    exp_last = 0;
    req = '0;
    observe(8'h3C, hi, nd, ne, na, bad, ended);
    chk("t3_hi", 32'(hi), 32'd10);
    chk("t3_done", 32'(nd), 32'd1);

    // watchdog timeout
    model_en = 1'b0;
    req = 4'b0010; req_data[15:8] = 8'h5A;
    check_grant("t4", rr_pick(req, exp_last), 8'h5A);
    req = '0;
    observe(8'h5A, hi, nd, ne, na, bad, ended);
    chk("t4_hi", 32'(hi), 32'(TO));
    chk("t4_err", 32'(ne), 32'd1);
    chk("t4_done", 32'(nd), 32'd0);
    chk("t4_idle", 32'(ended), 32'd1);
    model_en = 1'b1; frame_len = 5;
    req = 4'b0001; req_data[7:0] = 8'hC3;
    check_grant("t4b", rr_pick(req, exp_last), 8'hC3);
    req = '0;
    observe(8'hC3, hi, nd, ne, na, bad, ended);
    chk("t4b_done", 32'(nd), 32'd1);

    // reset in the middle of a frame
    frame_len = 100;
    req = 4'b0100; req_data[23:16] = 8'h77;
    check_grant("t5", rr_pick(req, exp_last), 8'h77);
    req = '0;
    repeat (10) tick();
    Reset_n = 1'b0;
    #1;
    chk("t5_sen", 32'(tx_send_en), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_err", 32'(err), 32'd0);
    repeat (3) tick();
    frame_len = 8;
    req = 4'b0011; req_data[15:0] = 16'hBEEF;
    Reset_n  = 1'b1;
    exp_last = N - 1;
    check_grant("t5b", rr_pick(req, exp_last), 8'hEF);
    req = '0;
    observe(8'hEF, hi, nd, ne, na, bad, ended);
    chk("t5b_done", 32'(nd), 32'd1);
    chk("t5b_err", 32'(ne), 32'd0);

    // withdrawn request never acknowledged
    frame_len = 20;
    req = 4'b0001; req_data[7:0] = 8'h96;
    check_grant("t6", rr_pick(req, exp_last), 8'h96);
    req = '0;
    tick();
    req[1] = 1'b1;
    tick();
    chk("t6_noack", 32'(ack), 32'd0);
    req[1] = 1'b0;
    observe(8'h96, hi, nd, ne, na, bad, ended);
    chk("t6_na", 32'(na), 32'd0);
    chk("t6_done", 32'(nd), 32'd1);
    idle_bad = 0;
    repeat (5) begin
      tick();
      if (busy || tx_send_en || ack != '0) idle_bad++;
    end
    chk("t6_idle", 32'(idle_bad), 32'd0);

    // randomized request patterns, data and frame lengths
    for (int it = 0; it < 30; it++) begin
      r         = $urandom_range(1, 15);
      req       = r[N-1:0];
      req_data  = $urandom;
      frame_len = $urandom_range(2, 20);
      w = rr_pick(req, exp_last);
      check_grant("rnd", w, req_data[8*w +: 8]);
      observe(req_data[8*w +: 8], hi, nd, ne, na, bad, ended);
      chk("rnd_hi", 32'(hi), 32'(frame_len));
      chk("rnd_done", 32'(nd), 32'd1);
      chk("rnd_err", 32'(ne), 32'd0);
      chk("rnd_na", 32'(na), 32'd0);
      chk("rnd_stable", 32'(bad), 32'd0);
    end
    req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
